data_storage: RTL and testbench
===============================

// Module: data_storage
// PURPOSE
// - Single-clock capture buffer between the ADC sample path and the byte-wide host/UART sender.
// - Accepts 32-bit sample words (4 packed 8-bit ADC bytes) and returns them one byte at a time.
// - Reports flow-control flags to both the producer and the consumer.
// PARAMETERS
// - DEPTH        16         word capacity of the FIFO; power of two, >=4
// - IN_W         32         input word width
// - OUT_W        8          output byte width; IN_W/OUT_W = 4 bytes per word
// - READY_LEVEL  DEPTH/2    stored-word count at which DataReadyToSend asserts
// PORTS
// - Clock            in   1      single system clock; rising edge
// - Reset            in   1      asynchronous, active-low reset
// - DataIn           in   32     sample word {DI, DID, DQ, DQD}
// - WriteEnable      in   1      write request for DataIn this cycle
// - ReadEnable       in   1      request for the next output byte
// - DataOut          out  8      output byte, registered
// - DataValid        out  1      1-cycle strobe: DataOut holds a new byte
// - FifoNotFull      out  1      high while a write will be accepted
// - DataReadyToSend  out  1      high while stored words >= READY_LEVEL
// BEHAVIOUR
// - Reset (Reset=0, any time): all state clears immediately; pointers, count, holding register and byte index go to 0.
//   Output reset values: DataOut=0, DataValid=0, FifoNotFull=1, DataReadyToSend=0.
// - Write: a word is stored when WriteEnable && FifoNotFull; the word is written at wr_ptr and wr_ptr wraps modulo DEPTH.
//   A write while full is dropped silently and causes no state change.
// - Read side: a holding register keeps the current word; byte_idx runs 0..3.
// - Read accept: a read is accepted when ReadEnable && (hold_valid || count>0).
//   - If byte_idx==0 and !hold_valid: pop the FIFO word into hold and emit byte 0 in the same cycle.
//   - Emitted byte = hold[8*byte_idx +: 8]: LSB-first order DQD, DQ, DID, DI.
//   - After byte 3: hold_valid clears and byte_idx returns to 0.
// - Read latency: DataOut/DataValid update on the clock edge that accepts the read, i.e. 1 cycle after ReadEnable is sampled.
//   - DataValid=0 on any cycle without an accepted read.
//   - DataOut holds its last value when no read is accepted.
// - A read while empty (no hold, count==0) is ignored and DataValid stays 0.
// - Simultaneous write and pop: count is unchanged.
//   A write when full is still rejected, even if a pop occurs in the same cycle.
// - FifoNotFull = (count != DEPTH), from the registered count.
// - DataReadyToSend = (count >= READY_LEVEL); it counts FIFO words only, excluding the holding register.
// - Count width is $clog2(DEPTH)+1, so full and empty are distinguished without a spare slot.
// CONFIGURATION
// - DATA_STORAGE_MSB_FIRST_EN defined: bytes are emitted MSB-first (DI, DID, DQ, DQD) using index 3-byte_idx.
// - Macro undefined (default): LSB-first as in BEHAVIOUR.
// - Flags, latency and reset behaviour are identical in both builds.
// STRUCTURE
// - Package data_storage_pkg holds:
//   - IN_W, OUT_W and BYTES_PER_WORD=IN_W/OUT_W constants
//   - typedef word_t (logic[IN_W-1:0])
//   - typedef byte_t (logic[OUT_W-1:0])
// - Sub-module data_storage_serializer: holding register, byte_idx and byte mux, with a pop request to the parent.
// - The parent owns the memory array, the pointers, count and the flag logic.
// TESTING
// - Reset mid-traffic: pull Reset low with 3 words stored.
//   -> asynchronous clear; FifoNotFull=1, DataReadyToSend=0, DataValid=0, DataOut=0.
// - Write one word 0x03010200 (DI=3, DID=1, DQ=2, DQD=0), then hold ReadEnable=1 for 5 cycles.
//   -> DataOut sequence 0x00, 0x02, 0x01, 0x03 with DataValid=1 for 4 cycles, then DataValid=0 on the empty read.
// - Fill: write 17 distinct words with no reads.
//   -> FifoNotFull falls after word 16; word 17 is dropped; DataReadyToSend=1 from word 8 onward.
//   - Drain all 64 bytes -> words 1..16 return in order; FifoNotFull rises after the first pop.
// - Toggle ReadEnable every cycle while writing continuously, with WriteEnable tied to FifoNotFull.
//   -> no lost or duplicated bytes; the byte stream matches the written words LSB-first.
// - Pointer wrap: perform 40 write/read word cycles at depth 16.
//   -> data stays correct across the wrap; count never exceeds 16.
// - Build with DATA_STORAGE_MSB_FIRST_EN and write 0x03010200 -> DataOut 0x03, 0x01, 0x02, 0x00.

Source files
------------

// File: rtl/data_storage_pkg.sv
// data_storage_pkg
// Shared widths and types for the ADC capture buffer (data_storage) and its
// byte serializer. A sample word is four packed ADC bytes {DI, DID, DQ, DQD}.
// Optional build macro used by the design: DATA_STORAGE_MSB_FIRST_EN.
package data_storage_pkg;

    localparam int IN_W           = 32;
    localparam int OUT_W          = 8;
    localparam int BYTES_PER_WORD = IN_W / OUT_W;

    typedef logic [IN_W-1:0]  word_t;
    typedef logic [OUT_W-1:0] byte_t;

endpackage : data_storage_pkg

// File: rtl/data_storage_serializer.sv
// data_storage_serializer
// Holds the word currently being sent and emits it one byte per accepted read.
// When nothing is held, an accepted read pops the FIFO head and emits its first
// byte on the same edge.
// Build option: DATA_STORAGE_MSB_FIRST_EN selects MSB-first byte order
// (DI, DID, DQ, DQD); otherwise bytes leave LSB-first (DQD, DQ, DID, DI).
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_rd_en        request for the next output byte
//   i_fifo_nempty  parent FIFO holds at least one word
//   i_fifo_head    word at the FIFO read pointer
//   o_pop          parent must advance its read pointer this cycle
//   o_data         registered output byte
//   o_valid        1-cycle strobe: o_data holds a new byte
module data_storage_serializer
    import data_storage_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_rd_en,
    input  logic  i_fifo_nempty,
    input  word_t i_fifo_head,
    output logic  o_pop,
    output byte_t o_data,
    output logic  o_valid
);

    localparam int IDX_W = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    word_t            r_hold;
    logic             r_hold_valid;
    logic [IDX_W-1:0] r_byte_idx;
    byte_t            r_data;
    logic             r_valid;

    logic             w_accept;
    logic             w_pop;
    word_t            w_word;
    logic [IDX_W-1:0] w_sel;
    byte_t            w_bytes [BYTES_PER_WORD];

    // byte_idx is always 0 whenever nothing is held, so !hold_valid alone
    // identifies the cycle that must pull a fresh word from the FIFO.
    assign w_accept = i_rd_en && (r_hold_valid || i_fifo_nempty);
    assign w_pop    = w_accept && !r_hold_valid;
    assign w_word   = r_hold_valid ? r_hold : i_fifo_head;

`ifdef DATA_STORAGE_MSB_FIRST_EN
    assign w_sel = LAST_IDX - r_byte_idx;
`else
    assign w_sel = r_byte_idx;
`endif

    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_byte_lane
            assign w_bytes[gi] = w_word[gi*OUT_W +: OUT_W];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_byte_idx   <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_data <= w_bytes[w_sel];
                if (w_pop) begin
                    r_hold       <= i_fifo_head;
                    r_hold_valid <= 1'b1;
                end
                if (r_byte_idx == LAST_IDX) begin
                    r_hold_valid <= 1'b0;
                    r_byte_idx   <= '0;
                end else begin
                    r_byte_idx <= r_byte_idx + IDX_W'(1);
                end
            end
        end
    end

    assign o_pop   = w_pop;
    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule : data_storage_serializer

// File: rtl/data_storage.sv
// data_storage
// Single-clock capture buffer between the ADC sample path and the byte-wide
// host/UART sender. Stores 32-bit sample words in a DEPTH-entry FIFO and returns
// them one byte per accepted read through data_storage_serializer.
// Build option: DATA_STORAGE_MSB_FIRST_EN (byte order, see serializer).
// Parameters:
//   DEPTH        FIFO word capacity (power of two, >= 4)
//   READY_LEVEL  stored-word count at which DataReadyToSend asserts
// Ports:
//   Clock            system clock, rising edge
//   Reset            asynchronous active-low reset
//   DataIn           sample word {DI, DID, DQ, DQD}
//   WriteEnable      write request for DataIn
//   ReadEnable       request for the next output byte
//   DataOut          registered output byte
//   DataValid        1-cycle strobe: DataOut holds a new byte
//   FifoNotFull      a write will be accepted this cycle
//   DataReadyToSend  FIFO word count (holding register excluded) >= READY_LEVEL
module data_storage
    import data_storage_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int READY_LEVEL = DEPTH / 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] DataIn,
    input  logic        WriteEnable,
    input  logic        ReadEnable,
    output logic [7:0]  DataOut,
    output logic        DataValid,
    output logic        FifoNotFull,
    output logic        DataReadyToSend
);

    localparam int PTR_W = $clog2(DEPTH);
    // One extra bit so a full FIFO (count == DEPTH) is distinct from empty.
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] READY_CNT = CNT_W'(READY_LEVEL);

    word_t            r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_write;
    logic             w_pop;
    word_t            w_head;

    // Fullness comes from the registered count only, so a pop in the same
    // cycle never frees a slot for a concurrent write.
    assign w_full  = (r_count == FULL_CNT);
    assign w_write = WriteEnable && !w_full;
    assign w_head  = r_mem[r_rd_ptr];

    // Storage array carries no reset so it can map onto distributed RAM.
    always_ff @(posedge Clock) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= DataIn;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    data_storage_serializer u_serializer (
        .i_clk         (Clock),
        .i_rst_n       (Reset),
        .i_rd_en       (ReadEnable),
        .i_fifo_nempty (r_count != '0),
        .i_fifo_head   (w_head),
        .o_pop         (w_pop),
        .o_data        (DataOut),
        .o_valid       (DataValid)
    );

    assign FifoNotFull     = !w_full;
    assign DataReadyToSend = (r_count >= READY_CNT);

endmodule : data_storage

// File: tb/tb_data_storage.sv
// Bench for data_storage: randomized traffic against a queue-based model of
// the buffer (a word queue plus a queue of bytes still to send from the
// current word).
module tb_data_storage;

    localparam int DEPTH = 16;
    localparam int READY = DEPTH / 2;

    logic        clk = 1'b0;
    logic        Reset;
    logic [31:0] DataIn;
    logic        WriteEnable;
    logic        ReadEnable;
    logic [7:0]  DataOut;
    logic        DataValid;
    logic        FifoNotFull;
    logic        DataReadyToSend;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0] wq[$];
    logic [7:0]  hq[$];
    logic [7:0]  m_out;
    logic        m_valid;

    always #5 clk = ~clk;

    data_storage #(.DEPTH(DEPTH)) dut (
        .Clock           (clk),
        .Reset           (Reset),
        .DataIn          (DataIn),
        .WriteEnable     (WriteEnable),
        .ReadEnable      (ReadEnable),
        .DataOut         (DataOut),
        .DataValid       (DataValid),
        .FifoNotFull     (FifoNotFull),
        .DataReadyToSend (DataReadyToSend)
    );

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
        logic [31:0] s;
`ifdef DATA_STORAGE_MSB_FIRST_EN
        s = w >> (8 * (3 - k));
`else
        s = w >> (8 * k);
`endif
        return s[7:0];
    endfunction

    task automatic model_reset();
        wq.delete();
        hq.delete();
        m_out   = 8'h00;
        m_valid = 1'b0;
    endtask

    // One clock of the model; fullness is judged before this cycle's pop.
    task automatic model_update(input logic we, input logic [31:0] din, input logic re);
        bit          was_full;
        logic [31:0] w;
        was_full = (wq.size() == DEPTH);
        m_valid  = 1'b0;
        if (re) begin
            if (hq.size() > 0) begin
                m_out   = hq.pop_front();
                m_valid = 1'b1;
            end else if (wq.size() > 0) begin
                w       = wq.pop_front();
                m_out   = byte_of(w, 0);
                m_valid = 1'b1;
                for (int k = 1; k < 4; k++) hq.push_back(byte_of(w, k));
            end
        end
        if (we && !was_full) wq.push_back(din);
    endtask

    task automatic step(input logic we, input logic [31:0] din, input logic re);
        WriteEnable = we;
        DataIn      = din;
        ReadEnable  = re;
        @(posedge clk);
        #1;
        model_update(we, din, re);
    endtask

    task automatic test_reset();
        Reset = 1'b0; WriteEnable = 1'b0; ReadEnable = 1'b0; DataIn = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (DataOut !== 8'h00) $display("FAIL reset DataOut got=%h exp=00", DataOut); else n_pass++;
        n_checks++; if (DataValid !== 1'b0) $display("FAIL reset DataValid got=%b exp=0", DataValid); else n_pass++;
        n_checks++; if (FifoNotFull !== 1'b1) $display("FAIL reset FifoNotFull got=%b exp=1", FifoNotFull); else n_pass++;
        n_checks++; if (DataReadyToSend !== 1'b0) $display("FAIL reset DataReadyToSend got=%b exp=0", DataReadyToSend); else n_pass++;
        Reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_word();
        logic [7:0] exp_seq [4];
`ifdef DATA_STORAGE_MSB_FIRST_EN
        exp_seq = '{8'h03, 8'h01, 8'h02, 8'h00};
`else
        exp_seq = '{8'h00, 8'h02, 8'h01, 8'h03};
`endif
        step(1'b1, 32'h03010200, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0, 1'b1);
            if (i < 4) begin
                n_checks++;
                if (DataValid !== 1'b1 || DataOut !== exp_seq[i])
                    $display("FAIL single byte%0d got v=%b d=%h exp v=1 d=%h", i, DataValid, DataOut, exp_seq[i]);
                else n_pass++;
            end else begin
                n_checks++;
                if (DataValid !== 1'b0 || DataOut !== exp_seq[3])
                    $display("FAIL single empty_read got v=%b d=%h exp v=0 d=%h", DataValid, DataOut, exp_seq[3]);
                else n_pass++;
            end
        end
        step(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 17; i++) begin
            step(1'b1, 32'hA500_0000 | 32'(i * 32'h0101), 1'b0);
            n_checks++;
            if (FifoNotFull !== (i < DEPTH) || DataReadyToSend !== (i >= READY))
                $display("FAIL fill word%0d got nf=%b rts=%b exp nf=%b rts=%b", i, FifoNotFull, DataReadyToSend, i < DEPTH, i >= READY);
            else n_pass++;
        end
        for (int i = 0; i < 66; i++) begin
            step(1'b0, 32'h0, 1'b1);
            n_checks++;
            if (DataValid !== m_valid || DataOut !== m_out || FifoNotFull !== (wq.size() != DEPTH) || DataReadyToSend !== (wq.size() >= READY))
                $display("FAIL drain cyc%0d got v=%b d=%h nf=%b rts=%b exp v=%b d=%h nf=%b rts=%b", i, DataValid, DataOut, FifoNotFull, DataReadyToSend, m_valid, m_out, wq.size() != DEPTH, wq.size() >= READY);
            else n_pass++;
        end
        n_checks++;
        if (DataValid !== 1'b0) $display("FAIL drain word17_dropped got v=%b exp v=0", DataValid); else n_pass++;
    endtask

    task automatic test_toggle_stream();
        logic re = 1'b0;
        for (int i = 0; i < 300; i++) begin
            re = ~re;
            step(FifoNotFull, $urandom, re);
            n_checks++;
            if (DataValid !== m_valid || DataOut !== m_out || FifoNotFull !== (wq.size() != DEPTH) || DataReadyToSend !== (wq.size() >= READY))
                $display("FAIL toggle cyc%0d got v=%b d=%h nf=%b rts=%b exp v=%b d=%h nf=%b rts=%b", i, DataValid, DataOut, FifoNotFull, DataReadyToSend, m_valid, m_out, wq.size() != DEPTH, wq.size() >= READY);
            else n_pass++;
        end
        while (wq.size() > 0 || hq.size() > 0) step(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_wrap();
        for (int w = 0; w < 40; w++) begin
            for (int b = 0; b < 4; b++) begin
                step(b == 0, $urandom, b != 0 || w > 0);
                n_checks++;
                if (DataValid !== m_valid || DataOut !== m_out || FifoNotFull !== 1'b1)
                    $display("FAIL wrap w%0d b%0d got v=%b d=%h nf=%b exp v=%b d=%h nf=1", w, b, DataValid, DataOut, FifoNotFull, m_valid, m_out);
                else n_pass++;
            end
        end
        while (wq.size() > 0 || hq.size() > 0) step(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 45), $urandom, ($urandom_range(0, 99) < 60));
            n_checks++;
            if (DataValid !== m_valid || DataOut !== m_out || FifoNotFull !== (wq.size() != DEPTH) || DataReadyToSend !== (wq.size() >= READY))
                $display("FAIL random cyc%0d got v=%b d=%h nf=%b rts=%b exp v=%b d=%h nf=%b rts=%b", i, DataValid, DataOut, FifoNotFull, DataReadyToSend, m_valid, m_out, wq.size() != DEPTH, wq.size() >= READY);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_traffic();
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        // Assert reset between clock edges: outputs must clear without an edge.
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        n_checks++; if (DataOut !== 8'h00) $display("FAIL midreset DataOut got=%h exp=00", DataOut); else n_pass++;
        n_checks++; if (DataValid !== 1'b0) $display("FAIL midreset DataValid got=%b exp=0", DataValid); else n_pass++;
        n_checks++; if (FifoNotFull !== 1'b1) $display("FAIL midreset FifoNotFull got=%b exp=1", FifoNotFull); else n_pass++;
        n_checks++; if (DataReadyToSend !== 1'b0) $display("FAIL midreset DataReadyToSend got=%b exp=0", DataReadyToSend); else n_pass++;
        @(posedge clk); #1;
        Reset = 1'b1;
        step(1'b0, 32'h0, 1'b1);
        n_checks++; if (DataValid !== 1'b0) $display("FAIL midreset empty_after got v=%b exp v=0", DataValid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill_drain();
        test_toggle_stream();
        test_wrap();
        test_random();
        test_reset_mid_traffic();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_data_storage
